// File: rtl/sy_ppl_mdu_iss.sv
// ---------------------------------------------------------------------------
// sy_ppl_mdu_iss -- in-order issue buffer and writeback-slot scheduler that
// sits in front of the MDU execute unit.
//
// Dispatch pushes MUL/MULH/DIV/REM micro-ops into a small FIFO. The head op
// is issued only when the MDU's single shared writeback slot is free at the
// op's completion cycle (tracked by the reservation vector resv) and, for
// divides, when the divider can take a new op. The MDU gives multiply
// priority on the writeback port, so this scheduling keeps a divide result
// from being dropped.
//
// Optional feature (compile-time macro SY_MDU_ISS_BYPASS_EN):
//   defined   - an op arriving at an empty FIFO that can issue right away
//               goes straight to the MDU in the same cycle and is not stored.
//   undefined - every op goes through the FIFO; there is no combinational
//               path from dis_* to mdu_*.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   flush_i                  pipeline flush (empties buffer and reservations)
//   dis_vld_i / dis_rdy_o    dispatch handshake
//   dis_*_i                  dispatched op fields
//   div_busy_i               divider busy, from the MDU
//   mdu_en_o                 issue strobe to the MDU
//   mdu_*_o                  fields of the op being issued
//   iss_empty_o, iss_cnt_o   FIFO status
// ---------------------------------------------------------------------------
package sy_ppl_mdu_pkg;
    typedef enum logic [1:0] {
        MDU_MUL  = 2'd0,
        MDU_MULH = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_REM  = 2'd3
    } mdu_opcode_e;
endpackage

module sy_ppl_mdu_iss
    import sy_ppl_mdu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int MUL_LAT     = 4,
    parameter int DIV_LAT     = 21,
    parameter int WIN         = DIV_LAT + 1,
    parameter int DWTH        = 64,
    parameter int PHY_REG_WTH = 6,
    parameter int ROB_WTH     = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       dis_vld_i,
    output logic                       dis_rdy_o,
    input  mdu_opcode_e                dis_opcode_i,
    input  logic                       dis_rs1_sign_i,
    input  logic                       dis_rs2_sign_i,
    input  logic [DWTH-1:0]            dis_rs1_data_i,
    input  logic [DWTH-1:0]            dis_rs2_data_i,
    input  logic [PHY_REG_WTH-1:0]     dis_rdst_idx_i,
    input  logic                       dis_is_32_i,
    input  logic [ROB_WTH-1:0]         dis_rob_idx_i,
    input  logic                       div_busy_i,
    output logic                       mdu_en_o,
    output mdu_opcode_e                mdu_opcode_o,
    output logic                       mdu_rs1_sign_o,
    output logic                       mdu_rs2_sign_o,
    output logic [DWTH-1:0]            mdu_rs1_data_o,
    output logic [DWTH-1:0]            mdu_rs2_data_o,
    output logic [PHY_REG_WTH-1:0]     mdu_rdst_idx_o,
    output logic                       mdu_is_32_o,
    output logic [ROB_WTH-1:0]         mdu_rob_idx_o,
    output logic                       iss_empty_o,
    output logic [$clog2(DEPTH):0]     iss_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        mdu_opcode_e            opcode;
        logic                   rs1_sign;
        logic                   rs2_sign;
        logic [DWTH-1:0]        rs1_data;
        logic [DWTH-1:0]        rs2_data;
        logic [PHY_REG_WTH-1:0] rdst_idx;
        logic                   is_32;
        logic [ROB_WTH-1:0]     rob_idx;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [WIN-1:0]     resv;
    logic               div_pend;

    entry_t             dis_entry, head, iss_entry;
    logic               head_vld, head_ok, byp_fire, iss_fire, push, pop;
    logic [WIN-1:0]     book;

    function automatic logic is_div(input mdu_opcode_e op);
        return (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // Slot check: resv[k] means the writeback port is taken k cycles from now.
    function automatic logic can_issue(input mdu_opcode_e op, input logic [WIN-1:0] rv,
                                       input logic busy, input logic pend);
        if (is_div(op))
            return !rv[DIV_LAT] && !busy && !pend;
        else
            return !rv[MUL_LAT];
    endfunction

    // NOTE: every signal assigned in this block gets a default first, so no latch can form.
    always_comb begin
        dis_entry = '{opcode:   dis_opcode_i,   rs1_sign: dis_rs1_sign_i,
                      rs2_sign: dis_rs2_sign_i, rs1_data: dis_rs1_data_i,
                      rs2_data: dis_rs2_data_i, rdst_idx: dis_rdst_idx_i,
                      is_32:    dis_is_32_i,    rob_idx:  dis_rob_idx_i};
        head      = mem[rd_ptr];
        head_vld  = (cnt != '0);
        head_ok   = head_vld && can_issue(head.opcode, resv, div_busy_i, div_pend);
`ifdef SY_MDU_ISS_BYPASS_EN
        byp_fire  = !flush_i && !head_vld && dis_vld_i
                    && can_issue(dis_opcode_i, resv, div_busy_i, div_pend);
`else
        byp_fire  = 1'b0;
`endif
        pop       = !flush_i && head_ok;
        iss_fire  = pop || byp_fire;
        push      = !flush_i && dis_vld_i && dis_rdy_o && !byp_fire;

        // Payload reads zero when nothing is held or bypassing.
        iss_entry = '0;
        if (head_vld)
            iss_entry = head;
`ifdef SY_MDU_ISS_BYPASS_EN
        else if (byp_fire)
            iss_entry = dis_entry;
`endif

        // Booking for next cycle: completion is L cycles away now, L-1 then.
        book = '0;
        if (iss_fire) begin
            if (is_div(iss_entry.opcode))
                book[DIV_LAT-1] = 1'b1;
            else
                book[MUL_LAT-1] = 1'b1;
        end
    end

    // Ready depends on the registered count only; a same-cycle pop does not help.
    assign dis_rdy_o      = (cnt != CNT_W'(DEPTH));
    assign mdu_en_o       = iss_fire;
    assign iss_empty_o    = !head_vld;
    assign iss_cnt_o      = cnt;
    assign mdu_opcode_o   = iss_entry.opcode;
    assign mdu_rs1_sign_o = iss_entry.rs1_sign;
    assign mdu_rs2_sign_o = iss_entry.rs2_sign;
    assign mdu_rs1_data_o = iss_entry.rs1_data;
    assign mdu_rs2_data_o = iss_entry.rs2_data;
    assign mdu_rdst_idx_o = iss_entry.rdst_idx;
    assign mdu_is_32_o    = iss_entry.is_32;
    assign mdu_rob_idx_o  = iss_entry.rob_idx;

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            resv     <= '0;
            div_pend <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            resv     <= (resv >> 1) | book;
            // Covers the cycle before div_busy_i rises after a divide issue.
            div_pend <= iss_fire && is_div(iss_entry.opcode);
        end
    end

    // NOTE: the entry storage has no reset; validity comes from cnt and the pointers.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= dis_entry;
    end

endmodule
